mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arb_pkg.sv | 31 +++
 rtl/mem_inflight_shreg.sv | 34 +++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizing for the cache-fill memory arbiter.
// Block geometry and memory pipeline depth are fixed here so all files agree.
package arb_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned MEM_LATENCY     = 4;
    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned OFFSET_BITS     = 4;
    localparam int unsigned BASE_W          = ADDR_W - OFFSET_BITS;
    localparam int unsigned CNT_W           = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE,
        FILL_I,
        FILL_D,
        WRITE
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // Words are 16-bit, so each word index steps the byte address by 2.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                     input logic [CNT_W-1:0]  idx);
        return {base, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_inflight_shreg.sv
// Valid+owner tag pipeline that tracks reads in flight to the memory.
// The head entry lines up with the cycle the memory returns that read.
module mem_inflight_shreg
    import arb_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_LATENCY
) (
    input  logic   clk,
    input  logic   clr,
    input  logic   shift_in_valid,
    input  owner_e shift_in_owner,
    output logic   head_valid,
    output owner_e head_owner,
    output logic   any_valid
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] owner_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], shift_in_valid};
            owner_q <= {owner_q[DEPTH-2:0], shift_in_owner};
        end
    end

    assign head_valid = valid_q[DEPTH-1];
    assign head_owner = owner_e'(owner_q[DEPTH-1]);
    assign any_valid  = |valid_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through words onto
// one pipelined memory port; fills issue 8 reads and route returns by tag.
module mem_arbiter
    import arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr_req,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [DATA_W-1:0] dcache_wr_data,
    output logic              icache_data_valid,
    output logic              dcache_data_valid,
    output logic              dcache_wr_ack,
    output logic [DATA_W-1:0] mem_data_out_q,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [BASE_W-1:0] base_q;
    logic [BASE_W-1:0] grant_base;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  ret_cnt_q;
    logic              issuing_q;
    logic              fill_grant;
    logic              issue_en;
    owner_e            issue_owner;
    logic              head_valid;
    owner_e            head_owner;
    logic              any_valid;
    logic              strobe;
    logic              last_ret;
    logic              unused_addr_bits;

    // Only the block base of a miss address matters; the word offset is regenerated.
    assign unused_addr_bits = ^{icache_addr[OFFSET_BITS-1:0], dcache_addr[OFFSET_BITS-1:0]};

    mem_inflight_shreg #(
        .DEPTH(MEM_LATENCY)
    ) u_inflight (
        .clk            (clk),
        .clr            (rst),
        .shift_in_valid (issue_en),
        .shift_in_owner (issue_owner),
        .head_valid     (head_valid),
        .head_owner     (head_owner),
        .any_valid      (any_valid)
    );

    assign issue_en       = issuing_q && (state_q == FILL_I || state_q == FILL_D);
    assign issue_owner    = (state_q == FILL_D) ? OWNER_D : OWNER_I;
    assign strobe         = mem_rvalid && head_valid;
    assign last_ret       = strobe && (ret_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));
    assign mem_data_out_q = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_grant = 1'b0;
        grant_base = '0;
        case (state_q)
            IDLE: begin
                if (!any_valid) begin
                    if (dcache_req) begin
                        state_d    = FILL_D;
                        fill_grant = 1'b1;
                        grant_base = dcache_addr[ADDR_W-1:OFFSET_BITS];
                    end else if (dcache_wr_req) begin
                        state_d = WRITE;
                    end else if (icache_req) begin
                        state_d    = FILL_I;
                        fill_grant = 1'b1;
                        grant_base = icache_addr[ADDR_W-1:OFFSET_BITS];
                    end
                end
            end
            FILL_I, FILL_D: begin
                if (last_ret) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // issuing_q stops the issue stream once the 3-bit counter wraps past the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            issuing_q   <= 1'b0;
        end else if (fill_grant) begin
            base_q      <= grant_base;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            issuing_q   <= 1'b1;
        end else begin
            if (issue_en) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                if (issue_cnt_q == '1) begin
                    issuing_q <= 1'b0;
                end
            end
            if (strobe) begin
                ret_cnt_q <= ret_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        mem_en            = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        dcache_wr_ack     = 1'b0;
        icache_data_valid = strobe && (head_owner == OWNER_I);
        dcache_data_valid = strobe && (head_owner == OWNER_D);
        case (state_q)
            FILL_I, FILL_D: begin
                if (issuing_q) begin
                    mem_en   = 1'b1;
                    mem_addr = word_addr(base_q, issue_cnt_q);
                end
            end
            WRITE: begin
                mem_en        = 1'b1;
                mem_wr        = 1'b1;
                mem_addr      = dcache_wr_addr;
                mem_wdata     = dcache_wr_data;
                dcache_wr_ack = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios then randomized traffic, checked every cycle against a
// transaction-level model of the arbiter plus a 4-cycle pipelined memory.
module tb_mem_arbiter;

    localparam int J_N = 0;
    localparam int J_I = 1;
    localparam int J_D = 2;
    localparam int J_W = 3;

    logic        clk;
    logic        rst;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic        dcache_req;
    logic [15:0] dcache_addr;
    logic        dcache_wr_req;
    logic [15:0] dcache_wr_addr;
    logic [15:0] dcache_wr_data;
    logic        icache_data_valid;
    logic        dcache_data_valid;
    logic        dcache_wr_ack;
    logic [15:0] mem_data_out_q;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    mem_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .icache_req        (icache_req),
        .icache_addr       (icache_addr),
        .dcache_req        (dcache_req),
        .dcache_addr       (dcache_addr),
        .dcache_wr_req     (dcache_wr_req),
        .dcache_wr_addr    (dcache_wr_addr),
        .dcache_wr_data    (dcache_wr_data),
        .icache_data_valid (icache_data_valid),
        .dcache_data_valid (dcache_data_valid),
        .dcache_wr_ack     (dcache_wr_ack),
        .mem_data_out_q    (mem_data_out_q),
        .mem_en            (mem_en),
        .mem_wr            (mem_wr),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_rvalid        (mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          own_d;
        int unsigned due;
    } pend_t;

    int          n_checks = 0;
    int          n_fails  = 0;
    int unsigned cyc      = 0;
    int unsigned t0       = 0;

    // Reference model: current job, its block base, words issued/returned, reads due.
    int          m_job      = J_N;
    logic [11:0] m_base     = '0;
    int          m_issued   = 0;
    int          m_returned = 0;
    bit          m_wr_done  = 0;
    pend_t       pend[$];

    // Memory environment: returns each read exactly 4 cycles after issue.
    logic [3:0]  mem_pipe = '0;
    logic [15:0] dp[4];

    int unsigned ob_iss_cyc[$];
    int unsigned ob_iss_addr[$];
    int unsigned ob_istb[$];
    int unsigned ob_dstb[$];
    int unsigned ob_wr[$];
    int unsigned ob_ack[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int unsigned qget(input int unsigned q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic obs_clear();
        ob_iss_cyc.delete();
        ob_iss_addr.delete();
        ob_istb.delete();
        ob_dstb.delete();
        ob_wr.delete();
        ob_ack.delete();
        t0 = cyc;
    endtask

    task automatic tick();
        logic        e_en, e_wr, e_ack, e_iv, e_dv;
        logic [15:0] e_addr, e_wd;
        bit          hit;
        int          job0;
        @(negedge clk);
        e_en = 0; e_wr = 0; e_ack = 0; e_addr = '0; e_wd = '0;
        if (m_job == J_W) begin
            e_en = 1; e_wr = 1; e_ack = 1;
            e_addr = dcache_wr_addr;
            e_wd   = dcache_wr_data;
        end else if ((m_job == J_I || m_job == J_D) && m_issued < 8) begin
            e_en   = 1;
            e_addr = {m_base, 4'h0} + 16'(2 * m_issued);
        end
        hit  = (pend.size() > 0) && (pend[0].due == cyc);
        e_iv = mem_rvalid && hit && !pend[0].own_d;
        e_dv = mem_rvalid && hit && pend[0].own_d;

        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("wr_ack", 32'(dcache_wr_ack), 32'(e_ack));
        chk("i_valid", 32'(icache_data_valid), 32'(e_iv));
        chk("d_valid", 32'(dcache_data_valid), 32'(e_dv));
        chk("rdata_pass", 32'(mem_data_out_q), 32'(mem_rdata));

        if (mem_en && !mem_wr) begin
            ob_iss_cyc.push_back(cyc);
            ob_iss_addr.push_back(32'(mem_addr));
        end
        if (mem_en && mem_wr) ob_wr.push_back(cyc);
        if (dcache_wr_ack) ob_ack.push_back(cyc);
        if (icache_data_valid) ob_istb.push_back(cyc);
        if (dcache_data_valid) ob_dstb.push_back(cyc);

        mem_pipe = {mem_pipe[2:0], mem_en && !mem_wr};
        dp[3] = dp[2]; dp[2] = dp[1]; dp[1] = dp[0]; dp[0] = 16'($urandom);

        m_wr_done = 0;
        if (rst) begin
            m_job = J_N; m_issued = 0; m_returned = 0;
            pend.delete();
        end else begin
            job0 = m_job;
            if (hit) begin
                void'(pend.pop_front());
                if (e_iv || e_dv) m_returned++;
            end
            if ((job0 == J_I || job0 == J_D) && m_issued < 8) begin
                pend.push_back(pend_t'{own_d: (job0 == J_D), due: cyc + 4});
                m_issued++;
            end
            if ((job0 == J_I || job0 == J_D) && m_returned == 8) m_job = J_N;
            if (job0 == J_W) begin
                m_job = J_N;
                m_wr_done = 1;
            end
            if (job0 == J_N && pend.size() == 0) begin
                if (dcache_req) begin
                    m_job = J_D; m_base = dcache_addr[15:4]; m_issued = 0; m_returned = 0;
                end else if (dcache_wr_req) begin
                    m_job = J_W;
                end else if (icache_req) begin
                    m_job = J_I; m_base = icache_addr[15:4]; m_issued = 0; m_returned = 0;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        mem_rvalid = mem_pipe[3];
        mem_rdata  = dp[3];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dp[i] = '0;
        rst = 1; icache_req = 0; icache_addr = '0; dcache_req = 0; dcache_addr = '0;
        dcache_wr_req = 0; dcache_wr_addr = '0; dcache_wr_data = '0;
        mem_rdata = '0; mem_rvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        rst = 0;

        // Single I fill from 0x1234; a D request arriving mid-fill waits for IDLE.
        obs_clear();
        icache_req = 1; icache_addr = 16'h1234;
        tick();
        icache_req = 0;
        run(2);
        dcache_req = 1; dcache_addr = 16'hBEEF;
        run(11);
        dcache_req = 0;
        run(14);
        chk("s1_istb_n", ob_istb.size(), 8);
        chk("s1_istb_first", qget(ob_istb, 0) - t0, 5);
        chk("s1_istb_last", qget(ob_istb, 7) - t0, 12);
        chk("s1_iss0_cyc", qget(ob_iss_cyc, 0) - t0, 1);
        chk("s1_iss0_addr", qget(ob_iss_addr, 0), 32'h1230);
        chk("s1_iss7_cyc", qget(ob_iss_cyc, 7) - t0, 8);
        chk("s1_iss7_addr", qget(ob_iss_addr, 7), 32'h123E);
        chk("s1_dfill_cyc", qget(ob_iss_cyc, 8) - t0, 14);
        chk("s1_dfill_addr", qget(ob_iss_addr, 8), 32'hBEE0);
        chk("s1_dstb_n", ob_dstb.size(), 8);
        chk("s1_dstb_first", qget(ob_dstb, 0) - t0, 18);

        // Simultaneous requests: D fill first, I fill starts on IDLE re-entry.
        obs_clear();
        icache_req = 1; icache_addr = 16'h4000;
        dcache_req = 1; dcache_addr = 16'h5550;
        tick();
        dcache_req = 0;
        run(13);
        icache_req = 0;
        run(14);
        chk("s2_iss0_addr", qget(ob_iss_addr, 0), 32'h5550);
        chk("s2_dstb_n", ob_dstb.size(), 8);
        chk("s2_dstb_first", qget(ob_dstb, 0) - t0, 5);
        chk("s2_dstb_last", qget(ob_dstb, 7) - t0, 12);
        chk("s2_ifill_cyc", qget(ob_iss_cyc, 8) - t0, 14);
        chk("s2_ifill_addr", qget(ob_iss_addr, 8), 32'h4000);
        chk("s2_istb_n", ob_istb.size(), 8);
        chk("s2_istb_first", qget(ob_istb, 0) - t0, 18);

        // Write request during an I fill is held off until all returns are in.
        obs_clear();
        icache_req = 1; icache_addr = 16'h0100;
        tick();
        icache_req = 0;
        run(1);
        dcache_wr_req = 1; dcache_wr_addr = 16'hA5A5; dcache_wr_data = 16'h1357;
        run(13);
        dcache_wr_req = 0;
        run(3);
        chk("s3_istb_n", ob_istb.size(), 8);
        chk("s3_wr_n", ob_wr.size(), 1);
        chk("s3_wr_cyc", qget(ob_wr, 0) - t0, 14);
        chk("s3_ack_n", ob_ack.size(), 1);

        // Reset after three issues: late returns must not strobe.
        obs_clear();
        icache_req = 1; icache_addr = 16'h2220;
        tick();
        icache_req = 0;
        run(3);
        rst = 1;
        tick();
        rst = 0;
        run(10);
        chk("s4_iss_n", ob_iss_cyc.size(), 4);
        chk("s4_iss_last", qget(ob_iss_cyc, 3) - t0, 4);
        chk("s4_istb_n", ob_istb.size(), 0);
        chk("s4_dstb_n", ob_dstb.size(), 0);

        // Spurious mem_rvalid in IDLE and early in a fill is ignored.
        obs_clear();
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1;
            tick();
        end
        chk("s5_idle_strobes", ob_istb.size() + ob_dstb.size(), 0);
        obs_clear();
        icache_req = 1; icache_addr = 16'h3330;
        tick();
        icache_req = 0;
        tick();
        mem_rvalid = 1;
        tick();
        mem_rvalid = 1;
        tick();
        dcache_req = 1; dcache_addr = 16'h6660;
        run(10);
        dcache_req = 0;
        run(14);
        chk("s5_istb_n", ob_istb.size(), 8);
        chk("s5_istb_first", qget(ob_istb, 0) - t0, 5);
        chk("s5_istb_last", qget(ob_istb, 7) - t0, 12);
        chk("s5_next_cyc", qget(ob_iss_cyc, 8) - t0, 14);

        // Requester drops after two returns: fill still completes.
        obs_clear();
        icache_req = 1; icache_addr = 16'h7770;
        tick();
        run(6);
        icache_req = 0;
        run(10);
        chk("s6_iss_n", ob_iss_cyc.size(), 8);
        chk("s6_istb_n", ob_istb.size(), 8);
        chk("s6_istb_last", qget(ob_istb, 7) - t0, 12);

        // Randomized traffic with occasional resets and spurious returns.
        for (int k = 0; k < 1500; k++) begin
            if (!icache_req && $urandom_range(0, 7) == 0) begin
                icache_req = 1; icache_addr = 16'($urandom);
            end
            if (!dcache_req && $urandom_range(0, 9) == 0) begin
                dcache_req = 1; dcache_addr = 16'($urandom);
            end
            if (!dcache_wr_req && $urandom_range(0, 9) == 0) begin
                dcache_wr_req = 1; dcache_wr_addr = 16'($urandom); dcache_wr_data = 16'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            if (!mem_rvalid && $urandom_range(0, 9) == 0) mem_rvalid = 1;
            tick();
            rst = 0;
            if (m_job == J_I && $urandom_range(0, 2) == 0) icache_req = 0;
            if (m_job == J_D && $urandom_range(0, 2) == 0) dcache_req = 0;
            if (m_wr_done) dcache_wr_req = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
